// File: rtl/seq_divider_param.sv
// Radix-2 restoring shift-subtract divider with a fixed WIDTH-iteration latency and a start/busy/done handshake.
// Define SIGNED_DIV_EN for two's-complement operands (adds a FIX state for sign correction).
module seq_divider_param #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             clear_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic [1:0]       dbg_state
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [1:0] S_FIX  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] qsr_q, qsr_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             div_zero_q, div_zero_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             accept;
  logic [WIDTH:0]   trial;
`ifdef SIGNED_DIV_EN
  logic             neg_q_q, neg_q_d;
  logic             neg_r_q, neg_r_d;
`endif

  // Handshake: a start is taken only in IDLE with no done pulse showing; busy covers
  // the iteration cycles, done pulses once with results, nothing is queued.
  assign accept = (state_q == S_IDLE) && start && !done_q;

  // The top partial-remainder bit is always 0 before a shift, so WIDTH+1 bits suffice.
  assign trial = {1'b0, rem_q[WIDTH-2:0], qsr_q[WIDTH-1]} - {1'b0, dvs_q};

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      qsr_q       <= '0;
      dvs_q       <= '0;
      dvd_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      div_zero_q  <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
`ifdef SIGNED_DIV_EN
      neg_q_q     <= 1'b0;
      neg_r_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      qsr_q       <= qsr_d;
      dvs_q       <= dvs_d;
      dvd_q       <= dvd_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      div_zero_q  <= div_zero_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
`ifdef SIGNED_DIV_EN
      neg_q_q     <= neg_q_d;
      neg_r_q     <= neg_r_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = (divisor == '0) ? S_DONE : S_CALC;
`ifdef SIGNED_DIV_EN
      S_CALC: if (cnt_q == CNT_ONE) state_d = S_FIX;
`else
      S_CALC: if (cnt_q == CNT_ONE) state_d = S_DONE;
`endif
      S_FIX:  state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    rem_d = rem_q;
    qsr_d = qsr_q;
    dvs_d = dvs_q;
    dvd_d = dvd_q;
`ifdef SIGNED_DIV_EN
    neg_q_d = neg_q_q;
    neg_r_d = neg_r_q;
`endif
    if (accept) begin
      dvd_d = dividend;
      rem_d = '0;
      cnt_d = CNT_INIT;
`ifdef SIGNED_DIV_EN
      dvs_d   = divisor[WIDTH-1]  ? ('0 - divisor)  : divisor;
      qsr_d   = dividend[WIDTH-1] ? ('0 - dividend) : dividend;
      neg_q_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
      neg_r_d = dividend[WIDTH-1];
`else
      dvs_d = divisor;
      qsr_d = dividend;
`endif
    end else if (state_q == S_CALC) begin
      cnt_d = cnt_q - CNT_ONE;
      if (!trial[WIDTH]) begin
        rem_d = trial[WIDTH-1:0];
        qsr_d = {qsr_q[WIDTH-2:0], 1'b1};
      end else begin
        rem_d = {rem_q[WIDTH-2:0], qsr_q[WIDTH-1]};
        qsr_d = {qsr_q[WIDTH-2:0], 1'b0};
      end
    end
`ifdef SIGNED_DIV_EN
    else if (state_q == S_FIX) begin
      if (neg_q_q) qsr_d = '0 - qsr_q;
      if (neg_r_q) rem_d = '0 - rem_q;
    end
`endif
  end

  // Output registers: status flags follow the state one edge later; results load only in DONE.
  always_comb begin
    busy_d      = (state_q == S_CALC) || (state_q == S_FIX);
    done_d      = (state_q == S_DONE);
    div_zero_d  = div_zero_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    if (accept) begin
      div_zero_d = 1'b0;
    end else if (state_q == S_DONE) begin
      if (dvs_q == '0) begin
        div_zero_d  = 1'b1;
        quotient_d  = '1;
        remainder_d = dvd_q;
      end else begin
        div_zero_d  = 1'b0;
        quotient_d  = qsr_q;
        remainder_d = rem_q;
      end
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign div_zero  = div_zero_q;
  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_seq_divider_param.sv
// Directed bench for seq_divider_param (WIDTH=8); hand-computed vectors, build with SIGNED_DIV_EN for the signed set.
module tb_seq_divider_param;
  localparam int W = 8;
`ifdef SIGNED_DIV_EN
  localparam int LAT = W + 2;
`else
  localparam int LAT = W + 1;
`endif

  logic         clk = 1'b0;
  logic         clear_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy, done, div_zero;
  logic [W-1:0] quotient, remainder;
  logic [1:0]   dbg_state;

  int total = 0;
  int passed = 0;
  int failed = 0;

  always #5 clk = ~clk;

  seq_divider_param #(.WIDTH(W)) dut (
    .clk(clk), .clear_n(clear_n), .start(start),
    .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .div_zero(div_zero),
    .quotient(quotient), .remainder(remainder), .dbg_state(dbg_state)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic run(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [W-1:0] eq, input logic [W-1:0] er, input logic edz,
                     input int elat, input int ebusy, input bit hold);
    int lat;
    int nbusy;
    start = 1'b0;
    tick();
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    tick();
    check({tag, ".dz_cleared"}, 32'(div_zero), 32'(1'b0));
    if (hold) begin
      dividend = 8'd50;
      divisor  = 8'd3;
    end else begin
      start = 1'b0;
    end
    lat = 0;
    nbusy = 0;
    while (done !== 1'b1 && lat < 40) begin
      tick();
      lat++;
      if (busy === 1'b1) nbusy++;
    end
    check({tag, ".done"}, 32'(done), 32'(1'b1));
    check({tag, ".latency"}, 32'(lat), 32'(elat));
    check({tag, ".busy_cycles"}, 32'(nbusy), 32'(ebusy));
    check({tag, ".quotient"}, 32'(quotient), 32'(eq));
    check({tag, ".remainder"}, 32'(remainder), 32'(er));
    check({tag, ".div_zero"}, 32'(div_zero), 32'(edz));
    if (hold) begin
      tick();
      start = 1'b0;
      tick();
      check({tag, ".no_restart_busy"}, 32'(busy), 32'(1'b0));
      check({tag, ".no_restart_done"}, 32'(done), 32'(1'b0));
      check({tag, ".held_quotient"}, 32'(quotient), 32'(eq));
    end
  endtask

  initial begin
    clear_n = 1'b0;
    tick();
    tick();
    check("reset.busy", 32'(busy), 32'(1'b0));
    check("reset.done", 32'(done), 32'(1'b0));
    check("reset.div_zero", 32'(div_zero), 32'(1'b0));
    check("reset.quotient", 32'(quotient), 32'(8'h00));
    check("reset.remainder", 32'(remainder), 32'(8'h00));
    clear_n = 1'b1;
    tick();

`ifdef SIGNED_DIV_EN
    run("neg7_div_2", 8'hF9, 8'h02, 8'hFD, 8'hFF, 1'b0, LAT, LAT - 1, 1'b0);
    run("mostneg_div_m1", 8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, LAT, LAT - 1, 1'b0);
    run("p7_div_m2", 8'h07, 8'hFE, 8'hFD, 8'h01, 1'b0, LAT, LAT - 1, 1'b0);
`else
    run("200_div_7", 8'd200, 8'd7, 8'd28, 8'd4, 1'b0, LAT, LAT - 1, 1'b0);
    run("7_div_200", 8'd7, 8'd200, 8'd0, 8'd7, 1'b0, LAT, LAT - 1, 1'b0);
    run("255_div_1", 8'd255, 8'd1, 8'd255, 8'd0, 1'b0, LAT, LAT - 1, 1'b0);
    run("255_div_255", 8'd255, 8'd255, 8'd1, 8'd0, 1'b0, LAT, LAT - 1, 1'b0);
`endif
    run("100_div_100", 8'd100, 8'd100, 8'd1, 8'd0, 1'b0, LAT, LAT - 1, 1'b0);
    run("9_div_0", 8'd9, 8'd0, 8'hFF, 8'd9, 1'b1, 1, 0, 1'b0);
    run("100_div_10", 8'd100, 8'd10, 8'd10, 8'd0, 1'b0, LAT, LAT - 1, 1'b0);
    run("hold_100_div_7", 8'd100, 8'd7, 8'd14, 8'd2, 1'b0, LAT, LAT - 1, 1'b1);

    // Abort in the middle of an iteration run
    start = 1'b0;
    tick();
    dividend = 8'd200;
    divisor  = 8'd7;
    start    = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    check("abort.busy_before", 32'(busy), 32'(1'b1));
    clear_n = 1'b0;
    #1;
    check("abort.busy", 32'(busy), 32'(1'b0));
    check("abort.done", 32'(done), 32'(1'b0));
    check("abort.div_zero", 32'(div_zero), 32'(1'b0));
    check("abort.quotient", 32'(quotient), 32'(8'h00));
    check("abort.remainder", 32'(remainder), 32'(8'h00));
    tick();
    tick();
    clear_n = 1'b1;
    tick();
    run("post_abort_100_div_10", 8'd100, 8'd10, 8'd10, 8'd0, 1'b0, LAT, LAT - 1, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/seq_divider_param.md
Name: seq_divider_param

Overview:
- Parametrised successor to the repeated-subtraction divider.
- Radix-2 restoring shift-subtract unsigned divider with a fixed latency of WIDTH iterations, independent of operand values.
- Loads both operands in one cycle and reports completion with a start/busy/done handshake.
- Flags divide-by-zero and sits as a multi-cycle arithmetic unit behind a controlling FSM.

Parameters:
- WIDTH, 8, bit width of dividend, divisor, quotient and remainder (legal range 2..32).

Ports:
- clk  input  1  rising-edge clock
- clear_n  input  1  asynchronous active-low reset
- start  input  1  begin a division; sampled only in IDLE
- dividend  input  WIDTH  numerator, sampled on the start edge
- divisor  input  WIDTH  denominator, sampled on the start edge
- busy  output  1  high while a division is in progress
- done  output  1  one-cycle pulse when results become valid
- div_zero  output  1  last operation had divisor 0; held until the next accepted start
- quotient  output  WIDTH  result register, held until the next accepted start
- remainder  output  WIDTH  result register, held until the next accepted start

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (clk, clear_n). While clear_n=0:
  - busy=0, done=0, div_zero=0, quotient=0, remainder=0
  - FSM in IDLE, iteration counter 0
- FSM states:
  - IDLE: on start=1 at edge k, latch both operands and clear div_zero.
    - If divisor==0, go to DONE.
    - Otherwise load the partial remainder with 0, the quotient shift register with dividend and the counter with WIDTH, then go to CALC.
  - CALC: busy=1. Each edge:
    - trial = {partial_rem[WIDTH-2:0], q_msb} - divisor, computed in WIDTH+1 bits.
    - If trial is non-negative, the partial remainder takes the trial value and a 1 shifts into the quotient LSB.
    - Otherwise the partial remainder takes the shifted value and a 0 shifts in.
    - The counter decrements. When the counter reaches 1, the final iteration completes and the FSM goes to DONE.
  - DONE: done=1 for exactly one cycle, quotient and remainder outputs updated, busy=0. Next state is IDLE.
- Latency:
  - Normal case: start sampled at edge k; busy=1 after edges k+1..k+WIDTH; done=1 and results valid after edge k+WIDTH+1.
  - Divide-by-zero: done=1 after edge k+1.
- Divide-by-zero result: quotient = all ones, remainder = dividend, div_zero=1.
- start is ignored while busy=1 or done=1. It is not queued.
- Operands may change freely after the start edge. Internal copies are used.
- Output registers change only in DONE. Between operations they hold their last values.
- Boundary cases:
  - dividend < divisor gives quotient 0 and remainder = dividend.
  - dividend == divisor gives 1 and 0.
  - divisor==1 gives dividend and 0.
  - All-ones / all-ones gives 1 and 0.
- clear_n asserted mid-CALC aborts immediately and applies the reset values. The first start after release begins a fresh operation.
- No combinational path from inputs to outputs.

Optional Feature:
- Macro: SIGNED_DIV_EN.
- Defined: operands are two's complement.
  - The start edge latches the operand magnitudes and signs.
  - The magnitude division runs as above.
  - An extra FIX state, between CALC and DONE, negates the quotient if the signs differ. The remainder takes the sign of the dividend (truncation toward zero).
  - Latency becomes WIDTH+2 cycles.
  - Most-negative / -1 gives quotient = most-negative and remainder 0.
  - Divide-by-zero behaves as in the unsigned case: quotient all ones, remainder = dividend.
- Undefined: unsigned only, no FIX state, and the latency is as stated above.

Test Plan:
- WIDTH=8; dividend=200, divisor=7, start pulse at edge k -> busy high for 8 cycles; done=1 after edge k+9; quotient=28, remainder=4.
- dividend=7, divisor=200 -> quotient=0, remainder=7, div_zero=0. Then dividend=255, divisor=1 -> quotient=255, remainder=0.
- dividend=9, divisor=0 -> done after edge k+1; div_zero=1, quotient=0xFF, remainder=9. The next valid start clears div_zero.
- Start 200/7, then hold start=1 and change the operands during busy -> results are still 28 and 4; no second operation begins until IDLE.
- Assert clear_n=0 at the 4th CALC cycle -> all outputs read 0 immediately. After release, 100/10 -> quotient=10, remainder=0 with nominal latency.
- With SIGNED_DIV_EN, -7/2 -> quotient=0xFD (-3), remainder=0xFF (-1), done after edge k+10. With SIGNED_DIV_EN, -128/-1 -> quotient=0x80, remainder=0.
